bf_bus_responder: RTL and testbench
===================================

Name: bf_bus_responder

Overview:
- Bus target serving the BF interpreter core's initiator bus: bus_op, addr, val_out in; val_in out.
- Contains a program memory (host-loadable), a zero-initialised data tape, an input-byte FIFO and an output-byte FIFO.
- Generates the core's enable: it stalls the core while the tape is clearing, when an IO read finds no input, or when an IO write finds no room.
- Sits between the core and the chip's host/IO pins.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 8, bus/cell/IO byte width.
- PROG_DEPTH, 256, program memory words (power of 2).
- DATA_DEPTH, 256, data tape cells (power of 2).
- FIFO_DEPTH, 4, entries per IO FIFO (power of 2, at least 2).

Ports:
- clock  in  1  clock.
- reset  in  1  reset.
- bus_op  in  3  BusOp: None=0, ReadProg=1, ReadData=2, WriteData=3, ReadIo=4, WriteIo=5; 6/7 treated as None.
- addr  in  ADDR_WIDTH  bus address.
- val_out  in  DATA_WIDTH  write data from core.
- val_in  out  DATA_WIDTH  registered read data to core.
- run  in  1  external run request.
- core_enable  out  1  drives core enable; equals run & ~stall.
- stall  out  1  responder cannot complete the current op this cycle.
- busy  out  1  tape clear in progress.
- prog_wr_en  in  1  host program-load strobe.
- prog_wr_addr  in  $clog2(PROG_DEPTH)  load address.
- prog_wr_data  in  DATA_WIDTH  load byte.
- in_valid / in_ready / in_data  in / out / in  1/1/DATA_WIDTH  input byte stream.
- out_valid / out_ready / out_data  out / in / out  1/1/DATA_WIDTH  output byte stream.

Behaviour:
- Reset is synchronous and active-high; clock is clock. Both were already decided.
- Reset values: val_in=0, FIFOs empty, out_valid=0, in_ready=0 while reset is high, busy=1 and stall=1 from the first cycle after reset.
- Program memory is not affected by reset.
- FSM CLEAR:
  - Counter walks 0..DATA_DEPTH-1, writing 0 to one cell per cycle.
  - busy=1, stall=1.
  - Transitions to RUN after writing the last cell. Clear takes exactly DATA_DEPTH cycles.
- FSM RUN: busy=0. Reset asserted in any state flushes both FIFOs and restarts CLEAR.
- An op "executes" in a cycle only when core_enable=1, i.e. run=1 and stall=0.
  - Because the core holds bus_op while disabled, a non-executing cycle has no side effects: no pop, no push, no write, no val_in update.
- stall in RUN is combinational:
  - 1 when bus_op=ReadIo and the input FIFO is empty.
  - 1 when bus_op=WriteIo and the output FIFO is full.
  - 0 otherwise.
- Read latency is 1. An op executed in cycle N updates val_in at the end of N; val_in is valid throughout N+1 and holds until the next executed read.
  - ReadProg: val_in = prog[addr] if addr < PROG_DEPTH, else 0x00 (halt byte).
  - ReadData: val_in = tape[addr mod DATA_DEPTH]. Address wraps, so 0xFFFF maps to cell DATA_DEPTH-1.
  - ReadIo: pops the input FIFO head into val_in.
- WriteData: tape[addr mod DATA_DEPTH] <= val_out. WriteIo: pushes val_out to the output FIFO. Neither write changes val_in.
- A prog_wr_en load is accepted in any state, including CLEAR.
  - If it coincides with an executed ReadProg to the same address, the read returns the old byte (read-before-write).
- Input FIFO: in_ready = ~full (no full pass-through); push on in_valid & in_ready.
  - Simultaneous push and pop when non-empty: both occur and the count is unchanged.
  - A push into an empty FIFO is visible (stall drops) the next cycle.
- Output FIFO: out_valid = ~empty; out_data = head; pop on out_valid & out_ready.
  - Push and pop in the same cycle are both allowed. When full with out_ready=1, stall stays 1 that cycle; the push happens in the next cycle.
- Byte order is preserved in both FIFOs. Overflow and underflow cannot occur by construction.

Test Plan:
- Reset pulse with run=1: stall=busy=1 and core_enable=0 for exactly 256 cycles, then core_enable=1. ReadData addr 0x0005 after that gives val_in=0x00.
- Load prog[0]=0x2B, then ReadProg addr 0x0000 executed at cycle N: val_in=0x2B during N+1. ReadProg addr 0x0100: val_in=0x00.
- WriteData addr 0x0003, val_out 0x41, then ReadData 0x0003: val_in=0x41. ReadData 0xFF03 also gives 0x41. A prior val_in value is unchanged by the write.
- ReadIo with input FIFO empty: stall=1 for 3 cycles. Push in_data=0x37 at cycle 3: stall=0 at cycle 4, val_in=0x37 at cycle 5, and exactly one pop occurs.
- out_ready=0 with WriteIo 0x48,0x69,0x21,0x0A accepted: the 5th WriteIo (0x3F) stalls. Raising out_ready drains 0x48,0x69,0x21,0x0A,0x3F in order with no loss.
- run=0 while bus_op=ReadIo and the FIFO holds 0x55: core_enable=0, no pop, val_in unchanged. Raising run pops 0x55 once.

Source files
------------

// File: rtl/bf_bus_responder.sv
// bf_byte_fifo: small power-of-two byte FIFO used for the IO streams.
// Ports: push/push_data write the tail, pop drops the head, head is the current
// head byte, empty/full report occupancy. Push when full and pop when empty are ignored.
module bf_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// bf_bus_responder: bus target for the BF core (program memory, data tape, IO FIFOs).
// Ports: bus_op/addr/val_out from core, val_in registered read data (1-cycle latency);
// run/core_enable/stall/busy control; prog_wr_* host load; in_*/out_* byte streams.
module bf_bus_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PROG_DEPTH = 256,
  parameter int DATA_DEPTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2:0]                    bus_op,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         val_out,
  output logic [DATA_WIDTH-1:0]         val_in,
  input  logic                          run,
  output logic                          core_enable,
  output logic                          stall,
  output logic                          busy,
  input  logic                          prog_wr_en,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_wr_addr,
  input  logic [DATA_WIDTH-1:0]         prog_wr_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data
);
  localparam int PROG_AW = $clog2(PROG_DEPTH);
  localparam int DATA_AW = $clog2(DATA_DEPTH);
  localparam logic [DATA_AW-1:0] CLR_LAST = DATA_AW'(DATA_DEPTH - 1);

  localparam logic [2:0] OP_RPROG = 3'd1;
  localparam logic [2:0] OP_RDATA = 3'd2;
  localparam logic [2:0] OP_WDATA = 3'd3;
  localparam logic [2:0] OP_RIO   = 3'd4;
  localparam logic [2:0] OP_WIO   = 3'd5;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_AW-1:0]  clr_cnt;
  logic                clearing;
  logic                exec;
  logic                prog_in_range;

  logic [DATA_WIDTH-1:0] prog_mem [PROG_DEPTH];
  logic [DATA_WIDTH-1:0] tape     [DATA_DEPTH];

  logic                  in_empty;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] in_head;
  logic                  out_empty;
  logic                  out_full;

  // State register and clear counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Next state and control outputs. Stall is forced while reset is held so
  // the core never executes against half-reset state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    clearing   = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        clearing = 1'b1;
        stall    = 1'b1;
        if (clr_cnt == CLR_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        stall = ((bus_op == OP_RIO) && in_empty) ||
                ((bus_op == OP_WIO) && out_full);
      end
    endcase
    if (reset) stall = 1'b1;
  end

  // An op has side effects only in a cycle the core is actually enabled.
  assign exec        = run & ~stall;
  assign core_enable = exec;

  assign prog_in_range = ((addr >> PROG_AW) == '0);

  // Program memory: host load in any state. Reads below see the pre-write
  // byte on a same-cycle collision because both sides use non-blocking updates.
  always_ff @(posedge clock) begin
    if (prog_wr_en) prog_mem[prog_wr_addr] <= prog_wr_data;
  end

  // Data tape: zeroed one cell per cycle during clear; address wraps modulo depth.
  always_ff @(posedge clock) begin
    if (clearing) begin
      tape[clr_cnt] <= '0;
    end else if (exec && (bus_op == OP_WDATA)) begin
      tape[addr[DATA_AW-1:0]] <= val_out;
    end
  end

  // Registered read data; holds until the next executed read.
  always_ff @(posedge clock) begin
    if (reset) begin
      val_in <= '0;
    end else if (exec) begin
      case (bus_op)
        OP_RPROG: val_in <= prog_in_range ? prog_mem[addr[PROG_AW-1:0]] : '0;
        OP_RDATA: val_in <= tape[addr[DATA_AW-1:0]];
        OP_RIO:   val_in <= in_head;
        default:  val_in <= val_in;
      endcase
    end
  end

  assign in_ready = ~in_full & ~reset;

  bf_byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid & in_ready),
    .push_data (in_data),
    .pop       (exec & (bus_op == OP_RIO)),
    .head      (in_head),
    .empty     (in_empty),
    .full      (in_full)
  );

  assign out_valid = ~out_empty;

  bf_byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (exec & (bus_op == OP_WIO)),
    .push_data (val_out),
    .pop       (out_valid & out_ready),
    .head      (out_data),
    .empty     (out_empty),
    .full      (out_full)
  );
endmodule

// File: tb/tb_bf_bus_responder.sv
// Directed bench for bf_bus_responder: read results and output bytes are
// queued as expected values when issued and compared by a negedge monitor.
module tb_bf_bus_responder;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_RPROG = 3'd1;
  localparam logic [2:0] OP_RDATA = 3'd2;
  localparam logic [2:0] OP_WDATA = 3'd3;
  localparam logic [2:0] OP_RIO   = 3'd4;
  localparam logic [2:0] OP_WIO   = 3'd5;

  logic        clock;
  logic        reset;
  logic [2:0]  bus_op;
  logic [15:0] addr;
  logic [7:0]  val_out;
  logic [7:0]  val_in;
  logic        run;
  logic        core_enable;
  logic        stall;
  logic        busy;
  logic        prog_wr_en;
  logic [7:0]  prog_wr_addr;
  logic [7:0]  prog_wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rd_q[$];
  string      rd_name[$];
  logic [7:0] out_q[$];
  bit         rd_pend = 0;

  bf_bus_responder dut (
    .clock        (clock),
    .reset        (reset),
    .bus_op       (bus_op),
    .addr         (addr),
    .val_out      (val_out),
    .val_in       (val_in),
    .run          (run),
    .core_enable  (core_enable),
    .stall        (stall),
    .busy         (busy),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a read executed in one cycle is checked on val_in the next cycle;
  // every output-stream handshake is checked against the expected byte order.
  always @(negedge clock) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_extra: unexpected executed read, val_in 0x%0h, expected none", val_in);
      end else begin
        check(rd_name.pop_front(), val_in, rd_q.pop_front());
      end
    end
    rd_pend = core_enable && (bus_op == OP_RPROG || bus_op == OP_RDATA || bus_op == OP_RIO);
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_extra: unexpected output byte 0x%0h, expected none", out_data);
      end else begin
        check("out_data", out_data, out_q.pop_front());
      end
    end
  end

  task automatic wait_exec(input string name);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      done = core_enable;
    end
    check({name, "_exec"}, done, 1);
  endtask

  task automatic issue_read(input logic [2:0] op, input logic [15:0] a,
                            input logic [7:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name.push_back(name);
    @(posedge clock); #1;
    bus_op = op;
    addr   = a;
    wait_exec(name);
    @(posedge clock); #1;
    bus_op = OP_NONE;
  endtask

  task automatic do_write(input logic [2:0] op, input logic [15:0] a,
                          input logic [7:0] v, input string name);
    @(posedge clock); #1;
    bus_op  = op;
    addr    = a;
    val_out = v;
    wait_exec(name);
    @(posedge clock); #1;
    bus_op = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         stall_cnt;
    int         busy_cnt;
    bit         done;
    logic [7:0] wio_bytes [4];

    reset = 1; run = 1; bus_op = OP_NONE; addr = 0; val_out = 0;
    prog_wr_en = 0; prog_wr_addr = 0; prog_wr_data = 0;
    in_valid = 0; in_data = 0; out_ready = 1;

    // Program loads are accepted while reset/clear is in progress.
    @(posedge clock); #1;
    prog_wr_en = 1; prog_wr_addr = 8'd0; prog_wr_data = 8'h2B;
    @(posedge clock); #1;
    prog_wr_addr = 8'd1; prog_wr_data = 8'h11;
    @(posedge clock); #1;
    prog_wr_en = 0;
    @(negedge clock);
    check("rst_val_in", val_in, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_enable", core_enable, 0);

    @(posedge clock); #1;
    reset = 0;
    stall_cnt = 0;
    busy_cnt  = 0;
    done      = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (core_enable) done = 1;
      else begin
        stall_cnt++;
        if (busy && stall) busy_cnt++;
      end
    end
    check("clear_done", done, 1);
    check("clear_stall_cycles", stall_cnt, 256);
    check("clear_busy_cycles", busy_cnt, 256);
    check("run_busy", busy, 0);

    // Tape was cleared; program memory kept its loads; out-of-range fetch halts.
    issue_read(OP_RDATA, 16'h0005, 8'h00, "rd_data_5");
    issue_read(OP_RPROG, 16'h0100, 8'h00, "rd_prog_100");
    issue_read(OP_RPROG, 16'h0000, 8'h2B, "rd_prog_0");

    do_write(OP_WDATA, 16'h0003, 8'h41, "wr_data_3");
    @(negedge clock);
    check("val_in_hold_after_write", val_in, 8'h2B);
    issue_read(OP_RDATA, 16'h0003, 8'h41, "rd_data_3");
    issue_read(OP_RDATA, 16'hFF03, 8'h41, "rd_data_ff03");
    do_write(OP_WDATA, 16'hFFFF, 8'h77, "wr_data_ffff");
    issue_read(OP_RDATA, 16'h00FF, 8'h77, "rd_data_ff");

    // Same-cycle load and fetch of one address returns the old byte.
    rd_q.push_back(8'h11); rd_name.push_back("rd_prog_collide");
    @(posedge clock); #1;
    bus_op = OP_RPROG; addr = 16'h0001;
    prog_wr_en = 1; prog_wr_addr = 8'd1; prog_wr_data = 8'h22;
    @(posedge clock); #1;
    bus_op = OP_NONE; prog_wr_en = 0;
    issue_read(OP_RPROG, 16'h0001, 8'h22, "rd_prog_after_load");

    // ReadIo against an empty input FIFO stalls until a byte arrives.
    rd_q.push_back(8'h37); rd_name.push_back("rd_io_37");
    @(posedge clock); #1;
    bus_op = OP_RIO; addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rio_empty_stall", stall, 1);
      check("rio_empty_enable", core_enable, 0);
    end
    @(posedge clock); #1;
    in_valid = 1; in_data = 8'h37;
    @(negedge clock);
    check("rio_push_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 0;
    @(negedge clock);
    check("rio_stall_drop", stall, 0);
    check("rio_enable", core_enable, 1);
    @(posedge clock); #1;
    bus_op = OP_NONE;
    @(negedge clock);
    @(posedge clock); #1;
    bus_op = OP_RIO;
    @(negedge clock);
    check("rio_single_pop", stall, 1);
    @(posedge clock); #1;
    bus_op = OP_NONE;

    // run=0 holds the core: no pop and val_in keeps its value.
    @(posedge clock); #1;
    in_valid = 1; in_data = 8'h55;
    @(posedge clock); #1;
    in_valid = 0; run = 0; bus_op = OP_RIO;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("run0_enable", core_enable, 0);
      check("run0_stall", stall, 0);
      check("run0_val_in", val_in, 8'h37);
    end
    rd_q.push_back(8'h55); rd_name.push_back("rd_io_55");
    @(posedge clock); #1;
    run = 1;
    @(posedge clock); #1;
    bus_op = OP_NONE;
    @(posedge clock); #1;
    bus_op = OP_RIO;
    @(negedge clock);
    check("run1_single_pop", stall, 1);
    @(posedge clock); #1;
    bus_op = OP_NONE;

    // Fill the output FIFO with the sink blocked, then drain in order.
    out_ready = 0;
    wio_bytes[0] = 8'h48; wio_bytes[1] = 8'h69; wio_bytes[2] = 8'h21; wio_bytes[3] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      out_q.push_back(wio_bytes[i]);
      do_write(OP_WIO, 16'h0000, wio_bytes[i], "wr_io");
    end
    out_q.push_back(8'h3F);
    @(posedge clock); #1;
    bus_op = OP_WIO; val_out = 8'h3F;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("wio_full_stall", stall, 1);
      check("wio_out_valid", out_valid, 1);
    end
    @(posedge clock); #1;
    out_ready = 1;
    @(negedge clock);
    check("wio_full_ready_stall", stall, 1);
    wait_exec("wr_io_3f");
    @(posedge clock); #1;
    bus_op = OP_NONE;
    repeat (10) @(posedge clock);
    @(negedge clock);

    check("out_drained", out_q.size(), 0);
    check("out_valid_idle", out_valid, 0);
    check("reads_all_seen", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
